// File: rtl/led_shift_driver_if.sv
// Pin bundle for the LED shift-register driver: pattern/enable in, serial bus and status out.
interface led_shift_driver_if;
    logic [15:0] led_i;
    logic        enable_i;
    logic        sclk_o;
    logic        sdata_o;
    logic        latch_o;
    logic        oe_n_o;
    logic        busy_o;
    logic [15:0] frame_count_o;

    // Driver side
    modport slave (
        input  led_i, enable_i,
        output sclk_o, sdata_o, latch_o, oe_n_o, busy_o, frame_count_o
    );

    // Pattern source / observer side
    modport master (
        output led_i, enable_i,
        input  sclk_o, sdata_o, latch_o, oe_n_o, busy_o, frame_count_o
    );
endinterface

// File: rtl/led_shift_driver.sv
// Serializes a 16-bit LED pattern MSB-first into an external shift-register
// chain, then pulses the storage latch. Resends on pattern change, on refresh
// timeout, or once after reset. All outputs are registered.
module led_shift_driver #(
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 40000,
    parameter bit INVERT         = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    led_shift_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    localparam logic [7:0]  DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [19:0] REFRESH_MAX = 20'(REFRESH_CYCLES);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [3:0]  idx, idx_nx;
    logic [15:0] shadow, shadow_nx;
    logic [15:0] last_sent, last_sent_nx;
    logic [19:0] refresh_cnt, refresh_nx;
    logic        sent, sent_nx;
    logic        sclk, sclk_nx;
    logic        sdata, sdata_nx;
    logic        latch, latch_nx;
    logic        busy, busy_nx;
    logic        oe_n, oe_n_nx;
    logic [15:0] frame_cnt, frame_cnt_nx;
    logic        half_done;

    assign half_done = (cnt == DIV_LAST);

    // Next-state and next-output computation for every register
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt + 8'd1;
        idx_nx       = idx;
        shadow_nx    = shadow;
        last_sent_nx = last_sent;
        refresh_nx   = refresh_cnt;
        sent_nx      = sent;
        sclk_nx      = sclk;
        sdata_nx     = sdata;
        latch_nx     = latch;
        busy_nx      = busy;
        oe_n_nx      = oe_n;
        frame_cnt_nx = frame_cnt;
        case (state)
            IDLE: begin
                cnt_nx = 8'd0;
                if (refresh_cnt != REFRESH_MAX)
                    refresh_nx = refresh_cnt + 20'd1;
                if (bus.enable_i && (bus.led_i != last_sent ||
                                     refresh_cnt == REFRESH_MAX || !sent)) begin
                    shadow_nx = bus.led_i;
                    busy_nx   = 1'b1;
                    sdata_nx  = bus.led_i[15] ^ INVERT;
                    sclk_nx   = 1'b0;
                    idx_nx    = 4'd15;
                    state_nx  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (half_done) begin
                    cnt_nx   = 8'd0;
                    sclk_nx  = 1'b1;
                    state_nx = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (half_done) begin
                    cnt_nx  = 8'd0;
                    sclk_nx = 1'b0;
                    if (idx != 4'd0) begin
                        idx_nx   = idx - 4'd1;
                        sdata_nx = shadow[idx - 4'd1] ^ INVERT;
                        state_nx = SHIFT_LO;
                    end else begin
                        latch_nx = 1'b1;
                        state_nx = LATCH;
                    end
                end
            end
            default: begin // LATCH
                if (half_done) begin
                    cnt_nx       = 8'd0;
                    latch_nx     = 1'b0;
                    busy_nx      = 1'b0;
                    sdata_nx     = 1'b0;
                    last_sent_nx = shadow;
                    frame_cnt_nx = frame_cnt + 16'd1;
                    oe_n_nx      = 1'b0;
                    refresh_nx   = 20'd0;
                    sent_nx      = 1'b1;
                    state_nx     = IDLE;
                end
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a latch pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            idx         <= 4'd0;
            shadow      <= 16'd0;
            last_sent   <= 16'd0;
            refresh_cnt <= 20'd0;
            sent        <= 1'b0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            latch       <= 1'b0;
            busy        <= 1'b0;
            oe_n        <= 1'b1;
            frame_cnt   <= 16'd0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            shadow      <= shadow_nx;
            last_sent   <= last_sent_nx;
            refresh_cnt <= refresh_nx;
            sent        <= sent_nx;
            sclk        <= sclk_nx;
            sdata       <= sdata_nx;
            latch       <= latch_nx;
            busy        <= busy_nx;
            oe_n        <= oe_n_nx;
            frame_cnt   <= frame_cnt_nx;
        end
    end

    assign bus.sclk_o        = sclk;
    assign bus.sdata_o       = sdata;
    assign bus.latch_o       = latch;
    assign bus.busy_o        = busy;
    assign bus.oe_n_o        = oe_n;
    assign bus.frame_count_o = frame_cnt;
endmodule

// File: doc/led_shift_driver.md
LED_SHIFT_DRIVER -- requirements
Module: led_shift_driver

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: shift-clock half-period in clock cycles; legal range 1..255.
REQ-002 The block SHALL have parameter REFRESH_CYCLES, default 40000: idle cycles before an unconditional re-send (~1 kHz at 40 MHz); legal range 1..2^20-1.
REQ-003 The block SHALL have parameter INVERT, default 0: when 1, every serialized bit is inverted (active-low LED drivers).
REQ-004 clock  in  1  40 MHz fabric clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 led_i  in  16  LED pattern from the LED control stage (led_out); bit 15 is shifted first.
REQ-007 enable_i  in  1  permits new frames to start.
REQ-008 sclk_o  out  1  shift clock to the external shift-register chain; the device samples on the rising edge.
REQ-009 sdata_o  out  1  serial data.
REQ-010 latch_o  out  1  storage-register latch pulse.
REQ-011 oe_n_o  out  1  active-low output enable for the driver chain.
REQ-012 busy_o  out  1  high while a frame is in progress.
REQ-013 frame_count_o  out  16  number of completed frames; wraps.

Function
REQ-014 The state machine SHALL have the states IDLE, SHIFT_LO, SHIFT_HI and LATCH, all registered; every output SHALL come directly from a flop.
REQ-015 IDLE: a frame SHALL start when enable_i=1 and at least one of the following holds:
- led_i differs from last_sent;
- refresh_cnt has reached REFRESH_CYCLES;
- no frame has been sent since reset.
REQ-016 On the starting edge the block SHALL do all of the following together:
- load shadow<=led_i;
- set busy_o=1 and sdata_o=led_i[15]^INVERT;
- hold sclk_o=0 and set bit index=15;
- enter SHIFT_LO.
REQ-017 SHIFT_LO SHALL last CLK_DIV cycles with sclk_o=0, then move to SHIFT_HI with sclk_o=1.
REQ-018 SHIFT_HI SHALL last CLK_DIV cycles with sdata_o stable.
REQ-019 On leaving SHIFT_HI with index>0, the block SHALL:
- set sclk_o=0;
- decrement index;
- drive sdata_o=shadow[index-1]^INVERT;
- return to SHIFT_LO.
REQ-020 On leaving SHIFT_HI with index=0, the block SHALL set sclk_o=0 and latch_o=1 and enter LATCH.
REQ-021 LATCH SHALL last CLK_DIV cycles; on exit the block SHALL do all of the following together:
- latch_o=0, busy_o=0, sdata_o=0;
- last_sent<=shadow;
- frame_count_o increments;
- oe_n_o=0;
- refresh_cnt=0;
- enter IDLE.
REQ-022 busy_o SHALL be high for exactly 33*CLK_DIV consecutive cycles per frame (132 at default), and sclk_o SHALL produce exactly 16 rising edges per frame.
REQ-023 Changes on led_i during a frame SHALL be ignored; the difference SHALL be detected in IDLE on the first cycle after the frame ends, so a new frame starts immediately with no dead cycle beyond that IDLE cycle.
REQ-024 refresh_cnt SHALL count only in IDLE, saturate at REFRESH_CYCLES, and clear at each frame end.
REQ-025 enable_i deasserted mid-frame SHALL NOT abort the frame; no new frame SHALL start while enable_i=0, and oe_n_o SHALL be unaffected by enable_i.
REQ-026 frame_count_o SHALL wrap from 0xFFFF to 0x0000.
REQ-027 The half-period counter SHALL be 8 bits wide and SHALL restart at every state transition.

Reset
REQ-028 While reset=1 the outputs SHALL be:
- sclk_o=0, sdata_o=0, latch_o=0, busy_o=0;
- oe_n_o=1;
- frame_count_o=0.
REQ-029 While reset=1 the internal state SHALL be: state=IDLE, shadow=0, last_sent=0, refresh_cnt=0, and the sent-since-reset flag cleared.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no latch pulse; oe_n_o SHALL stay 1 until the first complete frame after reset.

Verification
REQ-031 Reset release with enable_i=1 and led_i=16'hA5C3 (default parameters):
- sdata_o sampled at the 16 sclk_o rising edges = 1010010111000011;
- one latch_o pulse of 4 cycles;
- busy_o high 132 cycles, then frame_count_o=1 and oe_n_o=0.
REQ-032 INVERT=1, led_i=16'h0001: sampled bits = 1111111111111110.
REQ-033 led_i changed 16'h00FF->16'hFF00 at cycle 50 of a frame:
- the current frame completes with 00FF;
- the next frame starts one cycle after busy_o falls and carries FF00;
- frame_count_o advances by 2.
REQ-034 REFRESH_CYCLES=100, led_i constant: busy_o falling edges are spaced 133*... more precisely 132 busy + 101 idle cycles apart; frame_count_o increments by 1 each period; a run long enough to wrap 0xFFFF->0x0000 with no glitch on other outputs.
REQ-035 enable_i dropped mid-frame: the frame finishes normally and no further frame starts until enable_i=1; reset pulsed at cycle 70 of a frame: all outputs return to reset values asynchronously, latch_o never pulses, oe_n_o=1.
REQ-036 CLK_DIV=1: busy_o high 33 cycles; sclk_o toggles every cycle with 16 rising edges; latch_o high 1 cycle.
